detect_arbiter: RTL and testbench

Shares one 1-2-3 symbol-sequence detector between two symbol sources. It grants one source per packet, forwards that packet's 2-bit symbols to the detector, and counts detector matches. It returns a per-packet result record with a valid/ready handshake. The block sits upstream of result consumers, in place of direct detector instantiation per source.

---
 rtl/detect_pkg.sv | 22 ++
 rtl/seq_detect_123.sv | 51 +++++
 rtl/detect_arbiter.sv | 101 ++++++++++
 tb/tb_detect_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/detect_pkg.sv
// Shared types and constants for the 1-2-3 detector arbiter slice.
package detect_pkg;

  localparam int unsigned SYM_W = 2;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    REPORT
  } arb_state_t;

  typedef enum logic [1:0] {
    D0,
    D1,
    D12
  } det_state_t;

  localparam logic [SYM_W-1:0] PAT0 = 2'd1;
  localparam logic [SYM_W-1:0] PAT1 = 2'd2;
  localparam logic [SYM_W-1:0] PAT2 = 2'd3;

endpackage

// File: rtl/seq_detect_123.sv
// Mealy detector for the symbol sequence 1,2,3. Holds only its state;
// match is combinational on the current state and the enabled symbol.
module seq_detect_123
  import detect_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic [SYM_W-1:0] sym,
  output logic             match
);

  det_state_t state, state_nxt;

  // Next-state and match decode.
  always_comb begin
    state_nxt = state;
    match     = 1'b0;
    if (clr) begin
      state_nxt = D0;
    end else if (en) begin
      case (state)
        D0:  state_nxt = (sym == PAT0) ? D1 : D0;
        D1: begin
          if (sym == PAT0)      state_nxt = D1;
          else if (sym == PAT1) state_nxt = D12;
          else                  state_nxt = D0;
        end
        D12: begin
          if (sym == PAT2) begin
            match     = 1'b1;
            state_nxt = D0;
          end else if (sym == PAT0) begin
            state_nxt = D1;
          end else begin
            state_nxt = D0;
          end
        end
        default: state_nxt = D0;
      endcase
    end
  end

  // Detector state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= D0;
    else        state <= state_nxt;
  end

endmodule

// File: rtl/detect_arbiter.sv
// Arbitrates two symbol sources onto one 1-2-3 detector, one packet per
// grant, and returns a per-packet match count through a valid/ready port.
module detect_arbiter
  import detect_pkg::*;
#(
  parameter int unsigned CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  input  logic [SYM_W-1:0] req_sym0,
  input  logic [SYM_W-1:0] req_sym1,
  input  logic [1:0]       req_last,
  output logic [1:0]       req_ready,
  output logic             res_valid,
  output logic             res_src,
  output logic [CNT_W-1:0] res_count,
  input  logic             res_ready,
  output logic             busy
);

  arb_state_t       state;
  logic             prio;
  logic             g;
  logic [CNT_W-1:0] count;

  logic             gsel;
  logic [SYM_W-1:0] sym_sel;
  logic             accept;
  logic             last_acc;
  logic             det_clr;
  logic             match;
  logic [CNT_W-1:0] count_nxt;

  // Grant selection, symbol mux, accept qualification and saturating count.
  always_comb begin
    gsel      = (req_valid == 2'b11) ? prio : req_valid[1];
    sym_sel   = g ? req_sym1 : req_sym0;
    accept    = (state == STREAM) && req_valid[g] && req_ready[g];
    last_acc  = accept && req_last[g];
    det_clr   = (state == IDLE) && (|req_valid);
    count_nxt = count;
    if (accept && match && (count != '1)) count_nxt = count + 1'b1;
  end

  seq_detect_123 u_det (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (det_clr),
    .en    (accept),
    .sym   (sym_sel),
    .match (match)
  );

  // Arbitration FSM with registered handshake and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      prio      <= 1'b0;
      g         <= 1'b0;
      count     <= '0;
      req_ready <= '0;
      res_valid <= 1'b0;
      res_src   <= 1'b0;
      res_count <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|req_valid) begin
            g         <= gsel;
            count     <= '0;
            req_ready <= gsel ? 2'b10 : 2'b01;
            busy      <= 1'b1;
            state     <= STREAM;
          end
        end
        STREAM: begin
          count <= count_nxt;
          if (last_acc) begin
            req_ready <= '0;
            res_valid <= 1'b1;
            res_src   <= g;
            res_count <= count_nxt;
            state     <= REPORT;
          end
        end
        REPORT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            busy      <= 1'b0;
            prio      <= ~g;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_detect_arbiter.sv
// Directed bench for detect_arbiter: a CNT_W=4 instance and a CNT_W=2
// instance run in lockstep on the same stimulus.
module tb_detect_arbiter;

  logic       clk;
  logic       rst_n;
  logic [1:0] req_valid;
  logic [1:0] req_sym0;
  logic [1:0] req_sym1;
  logic [1:0] req_last;
  logic       res_ready;

  logic [1:0] req_ready;
  logic       res_valid;
  logic       res_src;
  logic [3:0] res_count;
  logic       busy;

  logic [1:0] n_req_ready;
  logic       n_res_valid;
  logic       n_res_src;
  logic [1:0] n_res_count;
  logic       n_busy;

  int checks;
  int errors;

  detect_arbiter #(.CNT_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_sym0  (req_sym0),
    .req_sym1  (req_sym1),
    .req_last  (req_last),
    .req_ready (req_ready),
    .res_valid (res_valid),
    .res_src   (res_src),
    .res_count (res_count),
    .res_ready (res_ready),
    .busy      (busy)
  );

  detect_arbiter #(.CNT_W(2)) dut_n (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_sym0  (req_sym0),
    .req_sym1  (req_sym1),
    .req_last  (req_last),
    .req_ready (n_req_ready),
    .res_valid (n_res_valid),
    .res_src   (n_res_src),
    .res_count (n_res_count),
    .res_ready (res_ready),
    .busy      (n_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_sym(input logic src, input logic [1:0] s, input logic l);
    if (src) begin
      req_sym1    = s;
      req_last[1] = l;
    end else begin
      req_sym0    = s;
      req_last[0] = l;
    end
  endtask

  // Streams n symbols from src; all actions happen at falling edges.
  task automatic send(input logic src, input logic [31:0] syms, input int n,
                      input logic has_last, input logic keep);
    int   idx;
    int   cyc;
    logic acc;
    logic other_bad;
    idx = 0;
    cyc = 0;
    other_bad = 1'b0;
    set_sym(src, syms[1:0], has_last && (n == 1));
    req_valid[src] = 1'b1;
    while (idx < n && cyc < 64) begin
      acc = req_ready[src];
      if (req_ready[~src] || n_req_ready !== req_ready) other_bad = 1'b1;
      @(negedge clk);
      cyc++;
      if (acc) begin
        idx++;
        if (idx < n) begin
          set_sym(src, syms[2*idx +: 2], has_last && (idx == n - 1));
        end else if (keep) begin
          set_sym(src, 2'd1, 1'b0);
        end else begin
          req_valid[src] = 1'b0;
          set_sym(src, 2'd0, 1'b0);
        end
      end
    end
    checks++;
    if (idx != n) begin
      errors++;
      $display("FAIL send_accepts src=%0d: accepted %0d, required %0d", src, idx, n);
    end
    checks++;
    if (other_bad) begin
      errors++;
      $display("FAIL other_ready src=%0d: non-granted ready seen high, required 0", src);
    end
  endtask

  // Checks the pending result and completes the handshake.
  task automatic consume(input logic esrc, input logic [3:0] ecnt, input logic [1:0] encnt);
    checks++;
    if (res_valid !== 1'b1 || n_res_valid !== 1'b1) begin
      errors++;
      $display("FAIL res_valid: got %b/%b, required 1", res_valid, n_res_valid);
    end
    checks++;
    if (res_src !== esrc || n_res_src !== esrc) begin
      errors++;
      $display("FAIL res_src: got %b/%b, required %b", res_src, n_res_src, esrc);
    end
    checks++;
    if (res_count !== ecnt) begin
      errors++;
      $display("FAIL res_count: got %0d, required %0d", res_count, ecnt);
    end
    checks++;
    if (n_res_count !== encnt) begin
      errors++;
      $display("FAIL res_count_narrow: got %0d, required %0d", n_res_count, encnt);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    checks++;
    if (res_valid !== 1'b0 || busy !== 1'b0 || n_busy !== 1'b0) begin
      errors++;
      $display("FAIL after_handshake: res_valid=%b busy=%b, required 0 0", res_valid, busy);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    checks++;
    if (req_ready !== 2'b00 || res_valid !== 1'b0 || res_src !== 1'b0 ||
        res_count !== 4'd0 || busy !== 1'b0 || n_req_ready !== 2'b00 ||
        n_res_valid !== 1'b0 || n_res_count !== 2'd0 || n_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s: ready=%b valid=%b src=%b count=%0d busy=%b, required all 0",
               tag, req_ready, res_valid, res_src, res_count, busy);
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    req_valid = 2'b11;
    req_sym0  = 2'd1;
    req_sym1  = 2'd3;
    req_last  = 2'b00;
    res_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_vals("reset_values");
    rst_n = 1'b1;
  endtask

  // Both sources pending from reset: src0 first, then src1, then src0 again.
  task automatic test_both();
    send(1'b0, 32'h39, 3, 1'b1, 1'b1);
    consume(1'b0, 4'd1, 2'd1);
    send(1'b1, 32'h1B, 3, 1'b1, 1'b0);
    consume(1'b1, 4'd0, 2'd0);
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b01) begin
      errors++;
      $display("FAIL alternate_grant: req_ready=%b, required 01", req_ready);
    end
    send(1'b0, 32'h1, 1, 1'b1, 1'b0);
    consume(1'b0, 4'd0, 2'd0);
  endtask

  task automatic test_single_src0();
    req_valid[0] = 1'b1;
    set_sym(1'b0, 2'd1, 1'b0);
    @(negedge clk);
    checks++;
    if (req_ready !== 2'b01 || busy !== 1'b1) begin
      errors++;
      $display("FAIL grant_latency: req_ready=%b busy=%b, required 01 1", req_ready, busy);
    end
    send(1'b0, 32'hE79, 6, 1'b1, 1'b0);
    consume(1'b0, 4'd2, 2'd2);
  endtask

  task automatic test_break();
    send(1'b1, 32'hE725, 8, 1'b1, 1'b0);
    consume(1'b1, 4'd1, 2'd1);
  endtask

  task automatic test_saturate();
    send(1'b0, {2'b00, {5{6'b111001}}}, 15, 1'b1, 1'b0);
    consume(1'b0, 4'd5, 2'd3);
  endtask

  task automatic test_stall();
    send(1'b0, 32'h39, 3, 1'b1, 1'b0);
    req_valid[1] = 1'b1;
    set_sym(1'b1, 2'd1, 1'b1);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (res_valid !== 1'b1 || res_src !== 1'b0 || res_count !== 4'd1 ||
          req_ready !== 2'b00 || busy !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold cyc=%0d: valid=%b src=%b count=%0d ready=%b busy=%b, required 1 0 1 00 1",
                 i, res_valid, res_src, res_count, req_ready, busy);
      end
      @(negedge clk);
    end
    consume(1'b0, 4'd1, 2'd1);
    send(1'b1, 32'h1, 1, 1'b1, 1'b0);
    consume(1'b1, 4'd0, 2'd0);
  endtask

  task automatic test_reset_mid();
    send(1'b0, 32'h9, 2, 1'b0, 1'b1);
    rst_n = 1'b0;
    #1;
    check_reset_vals("reset_mid_stream");
    req_valid = 2'b00;
    req_last  = 2'b00;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(1'b1, 32'hE7, 4, 1'b1, 1'b0);
    consume(1'b1, 4'd1, 2'd1);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_both();
    test_single_src0();
    test_break();
    test_saturate();
    test_stall();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
